// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and address helpers for the LBP host memory.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package lbp_pkg;

  localparam int IMG_WIDTH   = 128;
  localparam int DATA_WIDTH  = 8;
  localparam int ADDR_WIDTH  = 14;
  localparam int NPIX        = IMG_WIDTH * IMG_WIDTH;
  localparam int COORD_WIDTH = ADDR_WIDTH / 2;

  // Final raster address; also the saturation point of the write counter.
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(NPIX - 1);
  localparam logic [ADDR_WIDTH-1:0] WR_CNT_MAX = ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Address is {row, col}; the image side is a power of two, so the last
  // row/col index is all ones.
  function automatic logic is_border(input logic [ADDR_WIDTH-1:0] addr);
    logic [COORD_WIDTH-1:0] row;
    logic [COORD_WIDTH-1:0] col;
    row = addr[ADDR_WIDTH-1:COORD_WIDTH];
    col = addr[COORD_WIDTH-1:0];
    return (row == '0) || (&row) || (col == '0) || (&col);
  endfunction

endpackage

// File: rtl/lbp_host_ram.sv
// Image-sized RAM: one synchronous write port, one asynchronous read port.
// Latency: write commits at the clock edge; read is combinational (0 cycles).
// Backpressure: none; every write strobe is accepted.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module lbp_host_ram
  import lbp_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NPIX];

  // Contents are deliberately not reset; a fresh load overwrites them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle read of the address being written returns the old data.
  assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_host_mem.sv
// Memory-side responder for the LBP engine: load gray image, serve reads, capture results, drain.
// Latency: gray reads 0 cycles; result writes commit at the edge; finish->res_valid 1 cycle.
// Backpressure: ld_ready only in LOAD; res_ready low holds res_data/rd_ptr stable in DRAIN.
// Ports: ld_* byte stream in (raster order); gray_* engine read port; lbp_* engine write
//        port; finish from engine; res_* result stream out; wr_cnt, err, done status.
// Optional: define LBP_HOST_ADDR_CHECK_EN to enable the sticky err protocol checker.
module lbp_host_mem
  import lbp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  gray_req,
  input  logic [ADDR_WIDTH-1:0] gray_addr,
  output logic                  gray_ready,
  output logic [DATA_WIDTH-1:0] gray_data,
  input  logic                  lbp_valid,
  input  logic [ADDR_WIDTH-1:0] lbp_addr,
  input  logic [DATA_WIDTH-1:0] lbp_data,
  input  logic                  finish,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_last,
  output logic [ADDR_WIDTH-1:0] wr_cnt,
  output logic                  err,
  output logic                  done
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] ld_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic [DATA_WIDTH-1:0] gray_rd;
  logic [DATA_WIDTH-1:0] lbp_rd;
  logic                  gray_we;
  logic                  lbp_we;
  logic [ADDR_WIDTH-1:0] lbp_waddr;
  logic [DATA_WIDTH-1:0] lbp_wdata;

  // The engine samples its center pixel with gray_req low, so reads ignore it.
  logic unused_gray_req;
  assign unused_gray_req = gray_req;

  // Control FSM. The per-state strobes (ld_ready, gray_ready, res_valid,
  // done) are registered and switched on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_LOAD;
      ld_ptr     <= '0;
      rd_ptr     <= '0;
      wr_cnt     <= '0;
      ld_ready   <= 1'b1;
      gray_ready <= 1'b0;
      res_valid  <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (ld_valid) begin
            ld_ptr <= ld_ptr + ADDR_WIDTH'(1);
            if (ld_ptr == LAST_ADDR) begin
              state      <= ST_SERVE;
              ld_ready   <= 1'b0;
              gray_ready <= 1'b1;
            end
          end
        end
        ST_SERVE: begin
          if (lbp_valid && (wr_cnt != WR_CNT_MAX)) begin
            wr_cnt <= wr_cnt + ADDR_WIDTH'(1);
          end
          // A write in the finish cycle is still counted (and committed).
          if (finish) begin
            state      <= ST_DRAIN;
            gray_ready <= 1'b0;
            res_valid  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (res_ready) begin
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            if (rd_ptr == LAST_ADDR) begin
              state     <= ST_DONE;
              res_valid <= 1'b0;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          // DONE: terminal until reset; every strobe is ignored.
        end
      endcase
    end
  end

  // Load writes the pixel and clears the matching result location, so any
  // address the engine never writes (the border) drains as zero.
  assign gray_we = (state == ST_LOAD) && ld_valid;

  always_comb begin
    lbp_we    = 1'b0;
    lbp_waddr = ld_ptr;
    lbp_wdata = '0;
    case (state)
      ST_LOAD: begin
        lbp_we = ld_valid;
      end
      ST_SERVE: begin
        lbp_we    = lbp_valid;
        lbp_waddr = lbp_addr;
        lbp_wdata = lbp_data;
      end
      default: begin
        lbp_we = 1'b0;
      end
    endcase
  end

  lbp_host_ram u_gray_mem (
    .clk   (clk),
    .we    (gray_we),
    .waddr (ld_ptr),
    .wdata (ld_data),
    .raddr (gray_addr),
    .rdata (gray_rd)
  );

  lbp_host_ram u_lbp_mem (
    .clk   (clk),
    .we    (lbp_we),
    .waddr (lbp_waddr),
    .wdata (lbp_wdata),
    .raddr (rd_ptr),
    .rdata (lbp_rd)
  );

  // Outputs are forced to zero outside the state that owns them.
  assign gray_data = gray_ready ? gray_rd : '0;
  assign res_data  = res_valid ? lbp_rd : '0;
  assign res_last  = res_valid && (rd_ptr == LAST_ADDR);

`ifdef LBP_HOST_ADDR_CHECK_EN
  // Sticky flag: a result write to the image border, or any result write
  // outside SERVE. Offending SERVE writes are still committed above.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (lbp_valid && ((state != ST_SERVE) || is_border(lbp_addr))) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_lbp_host_mem.sv
// Bench for lbp_host_mem: randomized load/serve/drain against a count-based reference model.
// Latency: n/a.
// Backpressure: randomized and targeted res_ready stalls.
module tb_lbp_host_mem;

  localparam int NPIX = 16384;
  localparam int P_LOAD = 0, P_SERVE = 1, P_DRAIN = 2, P_DONE = 3;
`ifdef LBP_HOST_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [7:0]  ld_data;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_data;
  logic        res_last;
  logic [13:0] wr_cnt;
  logic        err;
  logic        done;

  lbp_host_mem dut (
    .clk        (clk),
    .reset      (reset),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_ready (gray_ready),
    .gray_data  (gray_data),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .wr_cnt     (wr_cnt),
    .err        (err),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (event counts, not pointers) ----------
  logic [7:0] gray_m [NPIX];
  logic [7:0] lbp_m  [NPIX];
  int m_loaded  = 0;
  int m_drained = 0;
  int m_wr      = 0;
  bit m_fin     = 1'b0;
  bit m_err     = 1'b0;

  function automatic int phase_of(input int loaded, input bit fin, input int drained);
    if (loaded < NPIX) return P_LOAD;
    if (!fin)          return P_SERVE;
    if (drained < NPIX) return P_DRAIN;
    return P_DONE;
  endfunction

  function automatic bit border(input int a);
    int r, c;
    r = a / 128;
    c = a % 128;
    return (r == 0) || (r == 127) || (c == 0) || (c == 127);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_loaded  <= 0;
      m_drained <= 0;
      m_wr      <= 0;
      m_fin     <= 1'b0;
      m_err     <= 1'b0;
    end else begin
      case (phase_of(m_loaded, m_fin, m_drained))
        P_LOAD: if (ld_valid) begin
          gray_m[m_loaded] <= ld_data;
          lbp_m[m_loaded]  <= 8'h00;
          m_loaded         <= m_loaded + 1;
        end
        P_SERVE: begin
          if (lbp_valid) begin
            lbp_m[lbp_addr] <= lbp_data;
            m_wr <= (m_wr < NPIX - 1) ? m_wr + 1 : m_wr;
          end
          if (finish) m_fin <= 1'b1;
        end
        P_DRAIN: if (res_ready) m_drained <= m_drained + 1;
        default: ;
      endcase
      if (CHK && lbp_valid &&
          ((phase_of(m_loaded, m_fin, m_drained) != P_SERVE) || border(int'(lbp_addr))))
        m_err <= 1'b1;
    end
  end

  // One compare per cycle over every output, sampled on the falling edge.
  always @(negedge clk) begin
    int ph;
    logic [7:0]  eg, er;
    logic [35:0] exp_v, act_v;
    ph = phase_of(m_loaded, m_fin, m_drained);
    eg = (ph == P_SERVE) ? gray_m[gray_addr] : 8'h00;
    er = (ph == P_DRAIN) ? lbp_m[m_drained] : 8'h00;
    exp_v = {ph == P_LOAD, ph == P_SERVE, eg, ph == P_DRAIN, er,
             (ph == P_DRAIN) && (m_drained == NPIX - 1), 14'(m_wr), ph == P_DONE, m_err};
    act_v = {ld_ready, gray_ready, gray_data, res_valid, res_data,
             res_last, wr_cnt, done, err};
    check("outputs_vs_model", act_v, exp_v);
  end

  // ---------------- stimulus ----------------
  logic [7:0] seen [NPIX];
  int last_cnt;
  int last_idx;

  task automatic check_reset_outputs(input string name);
    check(name, {ld_ready, gray_ready, gray_data, res_valid, res_data,
                 res_last, wr_cnt, done, err}, {1'b1, 35'b0});
  endtask

  // Entered and left at posedge+1.
  task automatic load_image(input bit rand_pix, input bit illegal);
    int i;
    gray_addr = 14'h0085;
    @(negedge clk);
    check("gray_data_in_load", gray_data, 8'h00);
    @(posedge clk); #1;
    i = 0;
    while (i < NPIX) begin
      ld_valid  = ($urandom_range(0, 7) != 0);
      ld_data   = rand_pix ? 8'($urandom) : 8'(i % 256);
      gray_addr = 14'($urandom);
      gray_req  = 1'($urandom);
      lbp_valid = illegal && ($urandom_range(0, 7) == 0);
      lbp_addr  = 14'($urandom);
      lbp_data  = 8'($urandom);
      if (ld_valid && i == NPIX - 1) begin
        @(negedge clk);
        check("gray_ready_before_last", gray_ready, 1'b0);
      end
      @(posedge clk); #1;
      if (ld_valid) i++;
    end
    ld_valid  = 1'b0;
    lbp_valid = 1'b0;
    @(negedge clk);
    check("gray_ready_rise", gray_ready, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [13:0] a, input logic [7:0] d, input bit fin);
    lbp_valid = 1'b1;
    lbp_addr  = a;
    lbp_data  = d;
    finish    = fin;
    @(posedge clk); #1;
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic serve_random(input int n);
    for (int k = 0; k < n; k++) begin
      gray_addr = 14'($urandom);
      gray_req  = 1'($urandom);
      lbp_valid = 1'($urandom);
      lbp_addr  = 14'($urandom_range(1, 126) * 128 + $urandom_range(1, 126));
      lbp_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    lbp_valid = 1'b0;
  endtask

  task automatic drain(input int stop_at, input bit bp, input bit rnd);
    int idx, cyc, held;
    idx = 0; cyc = 0; held = 0;
    last_cnt = 0; last_idx = -1;
    while (idx < stop_at && cyc < 3 * NPIX) begin
      res_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (bp && idx == 129 && held < 3) begin
        res_ready = 1'b0;
        held++;
      end
      lbp_valid = rnd && ($urandom_range(0, 31) == 0);
      lbp_addr  = 14'($urandom);
      @(negedge clk);
      if (bp && idx == 129 && !res_ready) check("bp_hold_data", res_data, 8'hA5);
      if (res_valid && res_ready) begin
        seen[idx] = res_data;
        if (res_last) begin
          last_cnt++;
          last_idx = idx;
        end
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    res_ready = 1'b0;
    lbp_valid = 1'b0;
    if (idx < stop_at) check("drain_timeout_beats", idx, stop_at);
  endtask

  initial begin
    int nz;
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- Sequence A: pattern load, random serve, partial drain, reset ----
    load_image(1'b0, 1'b0);
    gray_addr = 14'h0085; #1;
    check("gray_0085", gray_data, 8'h85);
    gray_addr = 14'h3FFF; #1;
    check("gray_3fff", gray_data, 8'hFF);
    gray_addr = 14'h2A10; #1;
    check("gray_2a10", gray_data, 8'h10);
    @(posedge clk); #1;
    serve_random(200);
    write(14'h0081, 8'h11, 1'b0);
    write(14'h0081, 8'h22, 1'b0);
    write(14'h0000, 8'h5A, 1'b0);
    @(negedge clk);
    check("err_border_write", err, CHK);
    @(posedge clk); #1;
    write(14'h0181, 8'h77, 1'b1);
    @(negedge clk);
    check("res_valid_after_finish", res_valid, 1'b1);
    check("first_beat_border_commit", res_data, 8'h5A);
    @(posedge clk); #1;
    drain(500, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_drain_reset_outputs");
    @(posedge clk); #1;
    reset = 1'b0;

    // ---- Sequence B: random load with illegal strobes, two writes, full drain ----
    load_image(1'b1, 1'b1);
    @(negedge clk);
    check("wr_cnt_after_illegal", wr_cnt, 14'd0);
    check("err_after_illegal", err, CHK);
    @(posedge clk); #1;
    serve_random(0);
    for (int k = 0; k < 10; k++) begin
      gray_addr = 14'($urandom);
      @(posedge clk); #1;
    end
    write(14'h0081, 8'hA5, 1'b0);
    write(14'h3F7E, 8'h0F, 1'b0);
    @(posedge clk); #1;
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    @(negedge clk);
    check("res_valid_one_cycle", res_valid, 1'b1);
    @(posedge clk); #1;
    drain(NPIX, 1'b1, 1'b0);
    @(negedge clk);
    check("done_after_last", done, 1'b1);
    check("wr_cnt_two", wr_cnt, 14'd2);
    check("res_valid_off", res_valid, 1'b0);
    check("beat_129", seen[129], 8'hA5);
    check("beat_128", seen[128], 8'h00);
    check("beat_16254", seen[16254], 8'h0F);
    nz = 0;
    for (int k = 0; k < NPIX; k++) if (seen[k] != 8'h00) nz++;
    check("nonzero_beats", nz, 2);
    check("res_last_count", last_cnt, 1);
    check("res_last_index", last_idx, 16383);
    @(posedge clk); #1;

    // Strobes in DONE are ignored.
    for (int k = 0; k < 8; k++) begin
      lbp_valid = 1'b1; ld_valid = 1'b1; finish = 1'b1; res_ready = 1'b1;
      @(posedge clk); #1;
    end
    lbp_valid = 1'b0; ld_valid = 1'b0; finish = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    check("done_sticky", done, 1'b1);
    check("wr_cnt_done", wr_cnt, 14'd2);
    check("ld_ready_done", ld_ready, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
